// File: rtl/booth_pkg.sv
// booth_pkg: shared types, defaults and helpers for the Booth accumulate stage.
//   acc_state_e  : accumulate FSM states (StAccum, StLast)
//   sext_product : sign-extends a src_w-bit product held in a MaxAccW-bit word
//   acc_max/min  : signed extremes of a w-bit accumulator, MaxAccW-bit encoded
package booth_pkg;

   // Widest accumulator the helpers support; callers truncate to ACC_WIDTH.
   localparam int unsigned MaxAccW = 64;

   localparam int unsigned WidthDef    = 8;
   localparam int unsigned AccLenDef   = 4;
   localparam int unsigned AccWidthDef = 2 * WidthDef + $clog2(AccLenDef);

   typedef enum logic {
      StAccum,
      StLast
   } acc_state_e;

   function automatic logic [MaxAccW-1:0] sext_product(input logic [MaxAccW-1:0] val,
                                                       input int unsigned        src_w);
      logic signed [MaxAccW-1:0] tmp;
      // Park the product's sign bit at the MSB, then shift back arithmetically.
      tmp = signed'(val << (MaxAccW - src_w));
      return tmp >>> (MaxAccW - src_w);
   endfunction

   function automatic logic [MaxAccW-1:0] acc_max(input int unsigned w);
      return (MaxAccW'(1) << (w - 1)) - MaxAccW'(1);
   endfunction

   function automatic logic [MaxAccW-1:0] acc_min(input int unsigned w);
      return ~acc_max(w);
   endfunction

   localparam logic [AccWidthDef-1:0] AccMaxDef = AccWidthDef'(acc_max(AccWidthDef));
   localparam logic [AccWidthDef-1:0] AccMinDef = AccWidthDef'(acc_min(AccWidthDef));

endpackage

// File: rtl/booth_sat_add.sv
// booth_sat_add: combinational signed adder for the accumulate stage.
// Build option BOOTH_ACC_SAT_EN: defined -> result clamps to the signed Width range and
// ovf_o flags the clamp; undefined -> result wraps and ovf_o is 0.
//   a_i, b_i : signed addends (Width bits)
//   sum_o    : signed sum (Width bits)
//   ovf_o    : result was clamped
module booth_sat_add
   import booth_pkg::*;
#(
   parameter int unsigned Width = 16
) (
   input  logic [Width-1:0] a_i,
   input  logic [Width-1:0] b_i,
   output logic [Width-1:0] sum_o,
   output logic             ovf_o
);

   logic [Width-1:0] raw_sum;

   assign raw_sum = a_i + b_i;

`ifdef BOOTH_ACC_SAT_EN
   localparam logic [Width-1:0] SumMax = Width'(acc_max(Width));
   localparam logic [Width-1:0] SumMin = Width'(acc_min(Width));

   logic ovf;

   // Overflow only when both addends share a sign the result does not.
   assign ovf = (a_i[Width-1] == b_i[Width-1]) && (raw_sum[Width-1] != a_i[Width-1]);

   always_comb begin
      sum_o = raw_sum;
      if (ovf) begin
         sum_o = a_i[Width-1] ? SumMin : SumMax;
      end
   end

   assign ovf_o = ovf;
`else
   assign sum_o = raw_sum;
   assign ovf_o = 1'b0;
`endif

endmodule

// File: rtl/booth_acc_stage.sv
// booth_acc_stage: sums groups of ACC_LEN signed products from the Booth multiplier and
// presents each group sum through a one-deep registered valid/ready output.
// Build option BOOTH_ACC_SAT_EN: saturating accumulation with sticky out_ovf_o.
//   clk_i, rst_ni             : clock, synchronous active-low reset
//   in_valid_i/in_ready_o     : product handshake, in_product_i signed 2*WIDTH
//   flush_i                   : discard the partial group (output register kept)
//   out_valid_o/out_ready_i   : sum handshake, out_sum_o signed ACC_WIDTH
//   out_ovf_o                 : group sum was clamped (0 without saturation)
//   busy_o                    : partial group in progress
module booth_acc_stage
   import booth_pkg::*;
#(
   parameter int unsigned WIDTH     = WidthDef,
   parameter int unsigned ACC_LEN   = AccLenDef,
   parameter int unsigned ACC_WIDTH = 2 * WIDTH + $clog2(ACC_LEN)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [2*WIDTH-1:0]   in_product_i,
   input  logic                 flush_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [ACC_WIDTH-1:0] out_sum_o,
   output logic                 out_ovf_o,
   output logic                 busy_o
);

   localparam int unsigned ProdW = 2 * WIDTH;
   localparam int unsigned CntW  = $clog2(ACC_LEN);
   localparam logic [CntW-1:0] CntPreLast = CntW'(ACC_LEN - 2);

   acc_state_e           state_q, state_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [ACC_WIDTH-1:0] out_sum_q, out_sum_d;
   logic                 out_valid_q, out_valid_d;
   logic [ACC_WIDTH-1:0] in_ext, add_sum, acc_next;
   logic                 add_ovf, accept;

`ifdef BOOTH_ACC_SAT_EN
   logic sticky_q, sticky_d;
   logic out_ovf_q, out_ovf_d;
`else
   logic unused_add_ovf;
   assign unused_add_ovf = add_ovf;
`endif

   assign in_ext = ACC_WIDTH'(sext_product(MaxAccW'(in_product_i), ProdW));

   booth_sat_add #(
      .Width (ACC_WIDTH)
   ) u_add (
      .a_i   (acc_q),
      .b_i   (in_ext),
      .sum_o (add_sum),
      .ovf_o (add_ovf)
   );

`ifdef BOOTH_ACC_SAT_EN
   // A clamped accumulator holds its value until the group closes.
   assign acc_next = sticky_q ? acc_q : add_sum;
`else
   assign acc_next = add_sum;
`endif

   // Only the closing beat can stall, and only when the held sum is not leaving.
   assign in_ready_o = !((state_q == StLast) && out_valid_q && !out_ready_i);
   assign accept     = in_valid_i && in_ready_o;

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      acc_d       = acc_q;
      out_sum_d   = out_sum_q;
      out_valid_d = out_valid_q;
`ifdef BOOTH_ACC_SAT_EN
      sticky_d    = sticky_q;
      out_ovf_d   = out_ovf_q;
`endif

      if (out_valid_q && out_ready_i) begin
         out_valid_d = 1'b0;
      end

      if (flush_i) begin
         // Flush beats any same-cycle accept, including a closing one.
         state_d  = StAccum;
         count_d  = '0;
         acc_d    = '0;
`ifdef BOOTH_ACC_SAT_EN
         sticky_d = 1'b0;
`endif
      end else if (accept) begin
         unique case (state_q)
            StAccum: begin
               acc_d   = acc_next;
               count_d = count_q + CntW'(1);
               if (count_q == CntPreLast) begin
                  state_d = StLast;
               end
`ifdef BOOTH_ACC_SAT_EN
               sticky_d = sticky_q | add_ovf;
`endif
            end
            StLast: begin
               out_sum_d   = acc_next;
               out_valid_d = 1'b1;
               acc_d       = '0;
               count_d     = '0;
               state_d     = StAccum;
`ifdef BOOTH_ACC_SAT_EN
               out_ovf_d   = sticky_q | add_ovf;
               sticky_d    = 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q     <= StAccum;
         count_q     <= '0;
         acc_q       <= '0;
         out_sum_q   <= '0;
         out_valid_q <= 1'b0;
`ifdef BOOTH_ACC_SAT_EN
         sticky_q    <= 1'b0;
         out_ovf_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         count_q     <= count_d;
         acc_q       <= acc_d;
         out_sum_q   <= out_sum_d;
         out_valid_q <= out_valid_d;
`ifdef BOOTH_ACC_SAT_EN
         sticky_q    <= sticky_d;
         out_ovf_q   <= out_ovf_d;
`endif
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_sum_o   = out_sum_q;
   assign busy_o      = (count_q != '0);
`ifdef BOOTH_ACC_SAT_EN
   assign out_ovf_o   = out_ovf_q;
`else
   assign out_ovf_o   = 1'b0;
`endif

endmodule

// File: tb/tb_booth_acc_stage.sv
// tb_booth_acc_stage: directed test of booth_acc_stage. Two instances share stimulus:
// dut (default ACC_WIDTH=18) and dut16 (ACC_WIDTH=16) for the saturation/wrap case.
module tb_booth_acc_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic [15:0] in_product;
   logic        flush;
   logic        out_ready;

   logic        in_ready, out_valid, out_ovf, busy;
   logic [17:0] out_sum;
   logic        in_ready16, out_valid16, out_ovf16, busy16;
   logic [15:0] out_sum16;

   int n_checks;
   int n_fail;

   booth_acc_stage dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_product_i (in_product),
      .flush_i      (flush),
      .out_valid_o  (out_valid),
      .out_ready_i  (out_ready),
      .out_sum_o    (out_sum),
      .out_ovf_o    (out_ovf),
      .busy_o       (busy)
   );

   booth_acc_stage #(
      .WIDTH     (8),
      .ACC_LEN   (4),
      .ACC_WIDTH (16)
   ) dut16 (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready16),
      .in_product_i (in_product),
      .flush_i      (flush),
      .out_valid_o  (out_valid16),
      .out_ready_i  (out_ready),
      .out_sum_o    (out_sum16),
      .out_ovf_o    (out_ovf16),
      .busy_o       (busy16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one product and hold it until accepted (bounded).
   task automatic send(input logic [15:0] prod);
      int waited;
      waited     = 0;
      in_valid   = 1'b1;
      in_product = prod;
      #0;
      while (!in_ready && waited < 20) begin
         step();
         waited++;
      end
      if (!in_ready) check("send_timeout", 32'd0, 32'd1);
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      in_product = '0;
      flush      = 1'b0;
      out_ready  = 1'b1;
      step();
      step();
      rst_n = 1'b1;

      // Reset state
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum",   32'(out_sum),   32'd0);
      check("rst_out_ovf",   32'(out_ovf),   32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);

      // Group 1: 0x55 + 0xAA - 85 + 0 = 170
      send(16'h0055);
      send(16'h00AA);
      send(16'hFFAB);
      check("g1_busy_mid", 32'(busy), 32'd1);
      check("g1_valid_pre", 32'(out_valid), 32'd0);
      send(16'h0000);
      check("g1_valid", 32'(out_valid), 32'd1);
      check("g1_sum",   32'(out_sum),   32'd170);
      check("g1_busy",  32'(busy),      32'd0);
      step();
      check("g1_consumed", 32'(out_valid), 32'd0);

      // Backpressure: first sum held while second group accumulates
      out_ready = 1'b0;
      send(16'd1);
      send(16'd2);
      send(16'd3);
      send(16'd4);
      check("bp_valid1", 32'(out_valid), 32'd1);
      check("bp_sum1",   32'(out_sum),   32'd10);
      send(16'd5);
      send(16'd6);
      send(16'd7);
      check("bp_hold_sum", 32'(out_sum), 32'd10);
      in_valid   = 1'b1;
      in_product = 16'd8;
      #1;
      check("bp_stall", 32'(in_ready), 32'd0);
      step();
      step();
      step();
      check("bp_stall_late", 32'(in_ready), 32'd0);
      check("bp_stable_sum", 32'(out_sum),  32'd10);
      check("bp_stable_vld", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      #1;
      check("bp_release", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("bp_valid2", 32'(out_valid), 32'd1);
      check("bp_sum2",   32'(out_sum),   32'd26);
      step();
      check("bp_consumed2", 32'(out_valid), 32'd0);

      // Flush after two beats, then four ones
      send(16'd10);
      send(16'd20);
      check("fl_busy_pre", 32'(busy), 32'd1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("fl_busy", 32'(busy), 32'd0);
      for (int i = 0; i < 4; i++) send(16'd1);
      check("fl_valid", 32'(out_valid), 32'd1);
      check("fl_sum",   32'(out_sum),   32'd4);
      step();

      // Flush on the closing beat: no output
      for (int i = 0; i < 3; i++) send(16'd1);
      in_valid   = 1'b1;
      in_product = 16'd1;
      flush      = 1'b1;
      step();
      in_valid = 1'b0;
      flush    = 1'b0;
      check("flc_valid", 32'(out_valid), 32'd0);
      check("flc_busy",  32'(busy),      32'd0);
      check("flc_sum",   32'(out_sum),   32'd4);

      // Reset mid-group with a pending output
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(16'd2);
      send(16'd3);
      check("rm_valid_pre", 32'(out_valid), 32'd1);
      check("rm_sum_pre",   32'(out_sum),   32'd8);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("rm_valid", 32'(out_valid), 32'd0);
      check("rm_sum",   32'(out_sum),   32'd0);
      check("rm_busy",  32'(busy),      32'd0);
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(16'd5);
      check("rm_valid2", 32'(out_valid), 32'd1);
      check("rm_sum2",   32'(out_sum),   32'd20);
      step();

      // Four 0x7FFF products: 16-bit accumulator saturates or wraps; 18-bit fits
      for (int i = 0; i < 4; i++) send(16'h7FFF);
      check("w18_sum", 32'(out_sum), 32'h1FFFC);
      check("w18_ovf", 32'(out_ovf), 32'd0);
      check("w16_valid", 32'(out_valid16), 32'd1);
`ifdef BOOTH_ACC_SAT_EN
      check("w16_sum", 32'(out_sum16), 32'h7FFF);
      check("w16_ovf", 32'(out_ovf16), 32'd1);
`else
      check("w16_sum", 32'(out_sum16), 32'hFFFC);
      check("w16_ovf", 32'(out_ovf16), 32'd0);
`endif
      step();

      // Following group must not inherit the overflow flag
      for (int i = 0; i < 4; i++) send(16'd1);
      check("w16_sum_next", 32'(out_sum16), 32'd4);
      check("w16_ovf_next", 32'(out_ovf16), 32'd0);
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
